// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter: lane index constants, the
// fault-cause encoding (also consumed by the trap unit) and the default
// memory word-index width.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DEF_ADDR_W = 10;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_e;

    // Classify a byte address: misalignment takes precedence over range.
    function automatic fault_e fault_cause(input logic [31:0] addr, input int addr_w);
        logic [31:0] hi_s;
        hi_s = addr >> (addr_w + 32'sd2);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end else if (hi_s != 32'd0) begin
            return FAULT_RANGE;
        end else begin
            return FAULT_NONE;
        end
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two load/store lane handshakes and the single data-memory port.
//   master : pipeline/memory side (drives requests and mem_rd)
//   slave  : arbiter side (drives grants, responses and the memory controls)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
    logic        l0_req;
    logic        l0_we;
    logic [31:0] l0_addr;
    logic [31:0] l0_wdata;
    logic        l0_gnt;
    logic        l0_rvalid;
    logic [31:0] l0_rdata;
    logic        l0_err;

    logic        l1_req;
    logic        l1_we;
    logic [31:0] l1_addr;
    logic [31:0] l1_wdata;
    logic        l1_gnt;
    logic        l1_rvalid;
    logic [31:0] l1_rdata;
    logic        l1_err;

    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output l0_req, l0_we, l0_addr, l0_wdata,
        input  l0_gnt, l0_rvalid, l0_rdata, l0_err,
        output l1_req, l1_we, l1_addr, l1_wdata,
        input  l1_gnt, l1_rvalid, l1_rdata, l1_err,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

    modport slave (
        input  l0_req, l0_we, l0_addr, l0_wdata,
        output l0_gnt, l0_rvalid, l0_rdata, l0_err,
        input  l1_req, l1_we, l1_addr, l1_wdata,
        output l1_gnt, l1_rvalid, l1_rdata, l1_err,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_rr_pick
// Two-way grant picker with an optional round-robin pointer.
//   clk, rst    : clock, asynchronous active-low reset (forces gnt to 0)
//   req0, req1  : lane requests
//   order_hold  : same-word hazard with a store; lane 0 (older) must win
//   gnt[1:0]    : one-hot grant, bit index = lane index
// The pointer only advances on contested cycles that were not decided by
// the ordering override, so the override never costs lane 1 its turn.
// -----------------------------------------------------------------------------
module dmem_rr_pick
    import dmem_pkg::*;
#(
    parameter int RR_EN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       order_hold,
    output logic [1:0] gnt
);

    logic ptr_r;

    // Combinational one-hot grant selection.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            gnt = 2'b00;
        end else if (req0 && req1) begin
            if (order_hold || (RR_EN == 0) || (ptr_r == LANE0)) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

    // Round-robin pointer: toggles after each contested, non-override cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= LANE0;
        end else if ((RR_EN != 0) && req0 && req1 && !order_hold) begin
            ptr_r <= ~ptr_r;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port word-addressed data memory between the two MEM-stage
// lanes (lane 0 = older instruction). At most one access is granted per
// cycle; the granted access is checked for alignment/range, drives the memory
// port, and receives a registered response one cycle later.
//   clk, rst      : clock, asynchronous active-low reset
//   bus           : lane handshakes and memory port (dmem_arbiter_if.slave)
//   conflict_cnt  : saturating count of cycles in which both lanes requested
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RR_EN  = 0,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    dmem_arbiter_if.slave      bus,
    output logic [CNT_W-1:0]   conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        gnt_s;
    logic              order_hold_s;
    logic              any_gnt_s;
    logic              sel_we_s;
    logic [31:0]       sel_addr_s;
    logic [31:0]       sel_wdata_s;
    fault_e            fault_s;
    logic              err_s;

    logic              l0_rvalid_r, l1_rvalid_r;
    logic              l0_err_r, l1_err_r;
    logic [31:0]       l0_rdata_r, l1_rdata_r;
    logic [CNT_W-1:0]  cnt_r;

    // A store and any other access to the same word must keep program order.
    assign order_hold_s = (bus.l0_addr[ADDR_W+1:2] == bus.l1_addr[ADDR_W+1:2]) &&
                          (bus.l0_we || bus.l1_we);

    dmem_rr_pick #(.RR_EN(RR_EN)) u_pick (
        .clk        (clk),
        .rst        (rst),
        .req0       (bus.l0_req),
        .req1       (bus.l1_req),
        .order_hold (order_hold_s),
        .gnt        (gnt_s)
    );

    // Select the granted lane's request and classify it.
    always_comb begin
        any_gnt_s   = gnt_s[LANE0] || gnt_s[LANE1];
        sel_we_s    = 1'b0;
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        if (gnt_s[LANE1]) begin
            sel_we_s    = bus.l1_we;
            sel_addr_s  = bus.l1_addr;
            sel_wdata_s = bus.l1_wdata;
        end else if (gnt_s[LANE0]) begin
            sel_we_s    = bus.l0_we;
            sel_addr_s  = bus.l0_addr;
            sel_wdata_s = bus.l0_wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = 32'd0;
            sel_wdata_s = 32'd0;
        end
        fault_s = fault_cause(sel_addr_s, ADDR_W);
        err_s   = any_gnt_s && (fault_s != FAULT_NONE);
    end

    // Memory port is idle (all zero) whenever nothing is granted.
    assign bus.mem_a  = {{(32-ADDR_W){1'b0}}, sel_addr_s[ADDR_W+1:2]};
    assign bus.mem_wd = sel_wdata_s;
    assign bus.mem_we = any_gnt_s && sel_we_s && !err_s;

    assign bus.l0_gnt = gnt_s[LANE0];
    assign bus.l1_gnt = gnt_s[LANE1];

    // One-cycle response registers and the saturating conflict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l0_rvalid_r <= 1'b0;
            l1_rvalid_r <= 1'b0;
            l0_err_r    <= 1'b0;
            l1_err_r    <= 1'b0;
            l0_rdata_r  <= 32'd0;
            l1_rdata_r  <= 32'd0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            l0_rvalid_r <= gnt_s[LANE0];
            l1_rvalid_r <= gnt_s[LANE1];
            l0_err_r    <= gnt_s[LANE0] && err_s;
            l1_err_r    <= gnt_s[LANE1] && err_s;
            l0_rdata_r  <= (gnt_s[LANE0] && !sel_we_s && !err_s) ? bus.mem_rd : 32'd0;
            l1_rdata_r  <= (gnt_s[LANE1] && !sel_we_s && !err_s) ? bus.mem_rd : 32'd0;
            if (bus.l0_req && bus.l1_req && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.l0_rvalid = l0_rvalid_r;
    assign bus.l1_rvalid = l1_rvalid_r;
    assign bus.l0_err    = l0_err_r;
    assign bus.l1_err    = l1_err_r;
    assign bus.l0_rdata  = l0_rdata_r;
    assign bus.l1_rdata  = l1_rdata_r;
    assign conflict_cnt  = cnt_r;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-addressed data memory between the two load/store lanes of the dual-issue pipeline.
- Lane 0 carries the older instruction of an issue pair; lane 1 carries the younger.
- Grants at most one access per cycle, checks alignment and range, drives the memory port, and returns a registered response one cycle after grant.
- Sits between the two MEM-stage lanes and the data memory; pipeline stall logic consumes the grant signals.

Parameters:
- ADDR_W, 10, memory word-index width (1024 words).
- RR_EN, 0, arbitration mode: 0 = fixed priority (lane 0 first); 1 = round-robin.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- l0_req  in  1  lane 0 access request
- l0_we  in  1  lane 0 write (1 = store, 0 = load)
- l0_addr  in  32  lane 0 byte address
- l0_wdata  in  32  lane 0 store data
- l0_gnt  out  1  lane 0 request accepted this cycle
- l0_rvalid  out  1  lane 0 response valid
- l0_rdata  out  32  lane 0 load data
- l0_err  out  1  lane 0 access faulted (with l0_rvalid)
- l1_req, l1_we, l1_addr, l1_wdata, l1_gnt, l1_rvalid, l1_rdata, l1_err  same widths and meanings as lane 0, for lane 1
- mem_we  out  1  memory write enable
- mem_a  out  32  memory word index, zero-extended from ADDR_W bits
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, combinational from mem_a
- conflict_cnt  out  CNT_W  cycles in which a request was denied

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst=0: l0_rvalid, l1_rvalid, l0_err, l1_err, l0_rdata, l1_rdata, conflict_cnt and the round-robin pointer are 0 (pointer = lane 0).
  - While rst=0: l0_gnt, l1_gnt and mem_we are forced to 0 combinationally.
  - A response pending when reset asserts is dropped; no rvalid follows reset release.
- Requests:
  - l*_req is sampled each cycle; there is no holding requirement.
  - A denied lane re-presents its request on the next cycle (the pipeline stalls on !gnt).
  - A request is accepted in the same cycle that gnt=1.
- Grant (combinational):
  - One requester: it is granted.
  - Both requesting, RR_EN=0: lane 0 wins.
  - Both requesting, RR_EN=1: the lane named by the pointer wins. The pointer toggles to the other lane after every cycle in which both requested.
  - Ordering override, both modes: if both request the same word index and at least one is a store, lane 0 wins. The pointer does not toggle in that cycle.
- Fault check on the granted request: err if addr[1:0]!=0, or if any bit of addr[31:ADDR_W+2] is 1.
- Memory drive:
  - mem_a = addr[ADDR_W+1:2] of the granted lane, zero-extended.
  - mem_wd = that lane's wdata.
  - mem_we = gnt & we & !err.
  - With no grant: mem_a=0, mem_wd=0, mem_we=0.
  - A faulting request never writes.
- Response (1-cycle latency):
  - On the posedge after a grant, the granted lane gets rvalid=1 for exactly one cycle.
  - rdata = mem_rd captured at the grant edge, for a non-faulting load; otherwise 0.
  - err = fault flag.
  - Stores also get rvalid (as the acknowledgement), with rdata=0.
  - The non-granted lane gets rvalid=0.
- Back-to-back grants: permitted every cycle, including alternating lanes. Responses follow in grant order, one per cycle.
- conflict_cnt: increments on each cycle with l0_req & l1_req; saturates at all-ones; no wrap.

Decomposition:
- Shared package dmem_pkg holds:
  - lane index constants LANE0=0 and LANE1=1
  - the fault-cause encoding (NONE, MISALIGN, RANGE), used internally and exported for the trap unit
  - the default ADDR_W
- One natural sub-module: dmem_rr_pick. It is the 2-way pick with pointer register and ordering override, and returns a one-hot grant.
- The fault check and response registers stay in the top level.

Test Plan:
- Single load: memory word 5 preloaded with 0xDEADBEEF; l0 load at address 0x14 → l0_gnt=1 the same cycle, mem_a=5; next cycle l0_rvalid=1, l0_rdata=0xDEADBEEF, l0_err=0.
- Conflict, RR_EN=0, lane 0 side: both lanes load different words (0x10 and 0x20) for 3 cycles → l0 is granted all 3 cycles, l1_gnt=0, conflict_cnt=3.
- Conflict, RR_EN=0, lane 1 side: continuing the previous case, l0 drops its request → l1 is granted on the next cycle, with its response 1 cycle later.
- Round-robin: RR_EN=1, both lanes request different words for 4 cycles → grants alternate L0, L1, L0, L1.
- Ordering override: RR_EN=1 with the pointer on lane 1; l0 stores 0x55 to 0x40 while l1 loads 0x40 → l0 is granted first. Next cycle l1 is granted and returns l1_rdata=0x55.
- Faults and reset:
  - l1 store to 0x41 → mem_we=0, l1_rvalid=1, l1_err=1, memory unchanged.
  - l0 load to 0x1000 (ADDR_W=10) → l0_err=1.
  - Assert rst mid-grant → mem_we=0 immediately, no rvalid after release, conflict_cnt=0.
